// File: rtl/block_store_sequencer.sv
// Store-multiple sequencer: walks a 16-bit register list low-to-high, streaming register-file
// reads out as memory writes, then reports the written-back base. Optional: BLOCK_STORE_ABORT_EN.
module block_store_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STEP   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [15:0]       i_reg_list,
  input  logic [DATA_W-1:0] i_base_addr,
  input  logic [1:0]        i_mode,
  output logic [3:0]        o_rf_addr,
  input  logic [DATA_W-1:0] i_rf_data,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic              i_mem_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_wb_valid,
`ifdef BLOCK_STORE_ABORT_EN
  input  logic              i_abort,
  output logic              o_aborted,
`endif
  output logic [DATA_W-1:0] o_wb_addr
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  localparam logic [DATA_W-1:0] StepW = DATA_W'(STEP);

  state_e            r_state;
  logic [15:0]       r_mask;
  logic [3:0]        r_rf_addr;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_wb_addr;
  logic              r_mem_we;
  logic              r_busy;
  logic              r_done;
  logic              r_wb_valid;
`ifdef BLOCK_STORE_ABORT_EN
  logic              r_aborted;
`endif

  logic [4:0]        w_cnt;
  logic [DATA_W-1:0] w_span;
  logic [DATA_W-1:0] w_first_addr;
  logic [DATA_W-1:0] w_final_addr;
  logic [15:0]       w_mask_next;

  function automatic logic [3:0] f_lowest(input logic [15:0] m);
    f_lowest = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) f_lowest = 4'(i);
    end
  endfunction

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      w_cnt = w_cnt + 5'(i_reg_list[i]);
    end
  end

  assign w_span      = DATA_W'(w_cnt) * StepW;
  // Clearing the lowest set bit retires the register just written.
  assign w_mask_next = r_mask & (r_mask - 16'd1);

  // Decrementing modes pre-compute the block bottom so words still go out in ascending order.
  always_comb begin
    w_first_addr = i_base_addr;
    unique case (i_mode)
      2'b00: w_first_addr = i_base_addr;
      2'b01: w_first_addr = i_base_addr + StepW;
      2'b10: w_first_addr = i_base_addr - w_span + StepW;
      2'b11: w_first_addr = i_base_addr - w_span;
      default: w_first_addr = i_base_addr;
    endcase
  end

  assign w_final_addr = i_mode[1] ? (i_base_addr - w_span) : (i_base_addr + w_span);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_mask     <= '0;
      r_rf_addr  <= '0;
      r_mem_addr <= '0;
      r_wb_addr  <= '0;
      r_mem_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wb_valid <= 1'b0;
`ifdef BLOCK_STORE_ABORT_EN
      r_aborted  <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_wb_valid <= 1'b0;
`ifdef BLOCK_STORE_ABORT_EN
      r_aborted  <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_mask     <= i_reg_list;
            r_mem_addr <= w_first_addr;
            r_wb_addr  <= w_final_addr;
            r_busy     <= 1'b1;
            if (i_reg_list != 16'd0) begin
              r_state   <= StWrite;
              r_mem_we  <= 1'b1;
              r_rf_addr <= f_lowest(i_reg_list);
            end else begin
              r_state    <= StDone;
              r_done     <= 1'b1;
              r_wb_valid <= 1'b1;
            end
          end
        end
        StWrite: begin
`ifdef BLOCK_STORE_ABORT_EN
          if (i_abort) begin
            r_state   <= StIdle;
            r_mask    <= '0;
            r_mem_we  <= 1'b0;
            r_busy    <= 1'b0;
            r_rf_addr <= '0;
            r_aborted <= 1'b1;
          end else
`endif
          if (i_mem_ready) begin
            r_mask     <= w_mask_next;
            r_mem_addr <= r_mem_addr + StepW;
            if (w_mask_next == 16'd0) begin
              r_state    <= StDone;
              r_mem_we   <= 1'b0;
              r_rf_addr  <= '0;
              r_done     <= 1'b1;
              r_wb_valid <= 1'b1;
            end else begin
              r_rf_addr <= f_lowest(w_mask_next);
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= StIdle;
          r_mem_we <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_rf_addr   = r_rf_addr;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = i_rf_data;
  assign o_mem_we    = r_mem_we;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_wb_valid  = r_wb_valid;
  assign o_wb_addr   = r_wb_addr;
`ifdef BLOCK_STORE_ABORT_EN
  assign o_aborted   = r_aborted;
`endif

endmodule

// File: doc/block_store_sequencer.md
# block_store_sequencer

Multi-register store sequencer for the datapath's block-transfer (STM-style) instructions. On a start pulse it walks a 16-bit register list from lowest to highest index. For each selected register it drives the register file's read address, forwards the read data as a memory write, and waits for the memory handshake. When the list is exhausted it reports the updated base address for writeback. It sits between the register file's read port 2 and the data-memory write interface, as the reader counterpart of the register-file write path.

## Interface
- DATA_W, 32: data and address width.
- STEP, 4: byte increment per transferred word.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin a transfer; sampled only in IDLE.
- reg_list  input  16  bit i set = store register i; latched on accepted start.
- base_addr  input  DATA_W  base address; latched on accepted start.
- mode  input  2  addressing mode: 00 IA, 01 IB, 10 DA, 11 DB; latched on accepted start.
- rf_addr  output  4  register-file read address.
- rf_data  input  DATA_W  combinational read data for rf_addr (r15 substitution is handled by the register file).
- mem_addr  output  DATA_W  write address.
- mem_wdata  output  DATA_W  write data; combinationally equal to rf_data.
- mem_we  output  1  write request; held until mem_ready.
- mem_ready  input  1  memory accepts the current write this cycle.
- busy  output  1  high in WRITE and DONE.
- done  output  1  one-cycle completion pulse.
- wb_valid  output  1  one-cycle pulse; coincident with done.
- wb_addr  output  DATA_W  final base value; valid while wb_valid is high.

## Operation
- States: IDLE, WRITE, DONE.
- IDLE:
  - On start, latch reg_list into a pending mask, and latch base_addr and mode.
  - n = popcount(reg_list).
  - First address: IA = base; IB = base+STEP; DA = base-STEP·n+STEP; DB = base-STEP·n.
  - Next state is WRITE if n>0, otherwise DONE.
  - start is ignored outside IDLE.
- WRITE:
  - rf_addr = index of the lowest set bit of the pending mask; mem_we = 1.
  - On mem_ready: clear that bit and add STEP to mem_addr.
  - If the mask becomes empty, go to DONE; otherwise stay in WRITE.
- DONE:
  - done = wb_valid = 1.
  - wb_addr = base+STEP·n for IA/IB, base-STEP·n for DA/DB.
  - Next state is IDLE.
- Address ordering: lowest-numbered register is always stored at the lowest address, in every mode.
- Arithmetic: modulo 2^DATA_W, with wrap-around permitted and not flagged.
- Outputs outside WRITE: rf_addr = 0, mem_we = 0.
- Outputs outside DONE: done = 0, wb_valid = 0.

## Timing
- Reset values: state IDLE; mask 0; mem_addr 0; wb_addr 0; rf_addr 0; mem_we, busy, done, wb_valid all 0. mem_wdata follows rf_data.
- Latency with mem_ready held high, start accepted at edge 0:
  - Writes complete at edges 1..n.
  - done is high during the cycle after edge n, i.e. n+1 cycles after start.
- Empty list: done and wb_valid are high in the cycle after start; no mem_we; wb_addr = base.
- Stalls: each cycle with mem_ready low extends WRITE by one cycle. mem_addr and rf_addr stay stable.
- start asserted in the same cycle as done is ignored; the earliest re-accept is the following cycle (IDLE).
- Reset asserted mid-transfer forces IDLE immediately (asynchronous). mem_we drops without waiting for the clock, and no done or wb_valid is produced.

## Configuration
- BLOCK_STORE_ABORT_EN defined:
  - Adds input abort (1) and output aborted (1).
  - abort high while in WRITE: return to IDLE at the next edge, regardless of mem_ready. mem_we is low from that edge on.
  - aborted pulses for one cycle; done and wb_valid are not asserted.
  - abort is ignored in IDLE and DONE.
- Undefined: neither port exists, and every started transfer runs to DONE.

## Test plan
- IA, reg_list=0x000E (r1–r3), base=0x100, mem_ready=1 -> writes r1@0x100, r2@0x104, r3@0x108 on edges 1–3; done and wb_valid at cycle 4, wb_addr=0x10C.
- DB, reg_list=0x8001 (r0, r15), base=0x200 -> r0@0x1F8, then r15@0x1FC (r15 value taken from the register file); wb_addr=0x1F8.
- IB, reg_list=0x0010, base=0x0, mem_ready low for 3 cycles -> mem_we and mem_addr=0x4 held for 4 cycles; done on the cycle after acceptance; wb_addr=0x4.
- reg_list=0x0000, DA, base=0x50 -> no mem_we; done and wb_valid one cycle after start; wb_addr=0x50. A start pulsed during the done cycle is ignored.
- IA, reg_list=0xFFFF, base=0xFFFFFFF0 -> 16 writes, with addresses wrapping past 0 to 0x0000002C; wb_addr=0x00000030.
- rst pulled low during the 2nd write -> mem_we and busy drop immediately, no done. With BLOCK_STORE_ABORT_EN, abort on the 2nd write gives aborted=1 one cycle later, and only 1 write is completed.
